uart_tx_framer: RTL

- Transmit half of the UART.
- Accepts a byte over a valid/ready handshake and serialises it as start, data LSB-first, optional parity, then stop bits onto txd.
- Sits between the TX holding path and the pin. It uses the same line-control fields (wls, stb, pen, eps, sp, bc) as the receive side, so both ends agree on frame format and parity polarity.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_parity_gen.sv | 27 ++
 rtl/uart_tx_framer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : FSM states, line-control struct and helpers shared by UART TX/RX
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_OSR_DEFAULT = 16;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
  } uart_lcr_t;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_parity_gen.sv
// ============================================================================
// uart_parity_gen : parity bit for the active word length (same rule as RX)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module uart_parity_gen (
  input  logic [7:0] data_i,
  input  logic [1:0] wls_i,
  input  logic       eps_i,
  input  logic       sp_i,
  output logic       parity_o
);

  logic [7:0] w_mask;
  logic       w_xor;

  always_comb begin
    w_mask   = 8'hFF >> (2'd3 - wls_i);
    w_xor    = ^(data_i & w_mask);
    // Stick parity forces the inverse of eps regardless of data.
    parity_o = sp_i ? ~eps_i : (eps_i ? w_xor : ~w_xor);
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_framer.sv
// ============================================================================
// uart_tx_framer : serialises a byte as start/data/parity/stop onto txd
// Optional       : UART_TX_HOLD_EN adds a one-entry holding register
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int OSR   = UART_OSR_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       txd,
  output logic       tx_busy
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(OSR / 2 - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  uart_lcr_t        lcr_q, lcr_d;

  logic       w_bit_last, w_stop_end, w_load, w_par, w_bit;
  logic       w_load_avail;
  logic [7:0] w_load_data;
  uart_lcr_t  w_load_lcr;
  logic [2:0] w_last_idx;

  assign w_bit_last = baud_tick && (cnt_q == C_LAST);
  assign w_last_idx = 3'(data_bits(lcr_q.wls) - 4'd1);
  // Second stop bit is cut to half a period for 5-bit words.
  assign w_stop_end = (state_q == ST_STOP) && baud_tick &&
                      (!lcr_q.stb ? (cnt_q == C_LAST) :
                       (idx_q[0] && (cnt_q == ((lcr_q.wls == WLS_5) ? C_HALF : C_LAST))));

`ifdef UART_TX_HOLD_EN
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_data_q;
  uart_lcr_t  hold_lcr_q;
  logic       w_accept;

  assign tx_ready     = ~hold_full_q;
  assign w_accept     = tx_valid & ~hold_full_q;
  assign w_load_avail = hold_full_q;
  assign w_load_data  = hold_data_q;
  assign w_load_lcr   = hold_lcr_q;
  assign w_load       = w_load_avail && ((state_q == ST_IDLE) || w_stop_end);
  assign hold_full_d  = (hold_full_q & ~w_load) | w_accept;
  assign tx_busy      = (state_q != ST_IDLE) | hold_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      hold_lcr_q  <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      if (w_accept) begin
        hold_data_q <= tx_data;
        hold_lcr_q  <= '{wls: wls, stb: stb, pen: pen, eps: eps, sp: sp};
      end
    end
  end
`else
  assign tx_ready     = (state_q == ST_IDLE);
  assign w_load_avail = tx_valid;
  assign w_load_data  = tx_data;
  assign w_load_lcr   = '{wls: wls, stb: stb, pen: pen, eps: eps, sp: sp};
  assign w_load       = w_load_avail && (state_q == ST_IDLE);
  assign tx_busy      = (state_q != ST_IDLE);
`endif

  uart_parity_gen u_parity (
    .data_i   (data_q),
    .wls_i    (lcr_q.wls),
    .eps_i    (lcr_q.eps),
    .sp_i     (lcr_q.sp),
    .parity_o (w_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      lcr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      lcr_q   <= lcr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    lcr_d   = lcr_q;
    w_bit   = 1'b1;
    if (baud_tick && (state_q != ST_IDLE)) begin
      cnt_d = w_bit_last ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      ST_START: begin
        w_bit = 1'b0;
        if (w_bit_last) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        w_bit = data_q[idx_q];
        if (w_bit_last) begin
          if (idx_q == w_last_idx) begin
            state_d = lcr_q.pen ? ST_PARITY : ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        w_bit = w_par;
        if (w_bit_last) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        w_bit = 1'b1;
        if (w_bit_last) idx_d = idx_q + 3'd1;
        if (w_stop_end) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    if (w_load) begin
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
      data_d  = w_load_data;
      lcr_d   = w_load_lcr;
    end
  end

  assign txd = ~bc & w_bit;

endmodule

`default_nettype wire
